// File: rtl/mem_port_sched.sv
// Arbitrates the single-port RAM between IF and MEM, sequences wait states and
// derives pipeline freeze/flush controls. Optional fetch buffer: IF_BUF_EN.
module mem_port_sched #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              hz_stall,
  input  logic              br_taken,
  input  logic [31:0]       ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              flush_if_id
);

  typedef enum logic [1:0] {IDLE, MEM_ACC, IF_ACC, DONE} state_e;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              abort_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic              ram_we_q;
  logic              ram_re_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       mem_rdata_q;
  logic              if_rdy_q;
  logic              mem_rdy_q;

  logic [ADDR_W-1:0] if_word;
  logic [ADDR_W-1:0] mem_word;
  logic              mem_req;
  logic              unused_addr_bits;

  assign if_word  = if_addr[ADDR_W+1:2];
  assign mem_word = mem_addr[ADDR_W+1:2];
  assign mem_req  = mem_rd | mem_wr;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2],
                              mem_addr[1:0], mem_addr[31:ADDR_W+2]};

`ifdef IF_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [31:0]       buf_instr_q;
  logic              buf_hit;

  assign buf_hit = buf_valid_q && (buf_addr_q == if_word);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_rdy_q    <= 1'b0;
      mem_rdy_q   <= 1'b0;
`ifdef IF_BUF_EN
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_instr_q <= '0;
`endif
    end else begin
      if_rdy_q  <= 1'b0;
      mem_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (mem_req) begin
            state_q     <= MEM_ACC;
            cnt_q       <= 4'd1;
            ram_addr_q  <= mem_word;
            ram_wdata_q <= mem_wdata;
            ram_we_q    <= mem_wr;
            ram_re_q    <= mem_rd;
          end else if (if_req) begin
`ifdef IF_BUF_EN
            if (buf_hit) begin
              if_rdata_q <= buf_instr_q;
              if_rdy_q   <= 1'b1;
              state_q    <= DONE;
            end else begin
`else
            begin
`endif
              state_q    <= IF_ACC;
              cnt_q      <= 4'd1;
              ram_addr_q <= if_word;
              ram_we_q   <= 1'b0;
              ram_re_q   <= 1'b1;
            end
          end
        end
        MEM_ACC: begin
          if (cnt_q == CNT_LAST) begin
            if (ram_re_q) mem_rdata_q <= ram_rdata;
            mem_rdy_q <= 1'b1;
            ram_we_q  <= 1'b0;
            ram_re_q  <= 1'b0;
            state_q   <= DONE;
`ifdef IF_BUF_EN
            if (ram_we_q && (buf_addr_q == ram_addr_q)) buf_valid_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        IF_ACC: begin
          if (br_taken) abort_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            // The fetch always lands in if_rdata; only the ready pulse is squashed.
            if_rdata_q <= ram_rdata;
            if_rdy_q   <= ~(abort_q | br_taken);
            ram_re_q   <= 1'b0;
            state_q    <= DONE;
`ifdef IF_BUF_EN
            buf_valid_q <= 1'b1;
            buf_addr_q  <= ram_addr_q;
            buf_instr_q <= ram_rdata;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          abort_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_rdy_q;
  // A branch resolved in the DONE cycle still squashes the registered pulse.
  assign if_ready  = if_rdy_q & ~br_taken;

  assign freeze_pipe = mem_req & ~mem_ready;
  assign freeze_if   = freeze_pipe | hz_stall | (if_req & ~if_ready);
  assign flush_if_id = br_taken & ~freeze_pipe;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a small behavioural RAM.
module tb_mem_port_sched;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          hz_stall;
  logic          br_taken;
  logic [31:0]   ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          freeze_if;
  logic          freeze_pipe;
  logic          flush_if_id;

  int checks = 0;
  int errors = 0;

  mem_port_sched #(.WAIT_CYCLES(5), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .hz_stall(hz_stall), .br_taken(br_taken), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .if_rdata(if_rdata), .if_ready(if_ready), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
    .flush_if_id(flush_if_id)
  );

  always #5 clk = ~clk;

  // RAM: unwritten words read as {A5A5, word address}.
  logic        ram_clr;
  logic [31:0] ram_mem [0:15];
  logic [15:0] wr_valid;

  always @(posedge clk) begin
    if (ram_clr) wr_valid <= '0;
    else if (ram_we) begin
      ram_mem[ram_addr[3:0]]  <= ram_wdata;
      wr_valid[ram_addr[3:0]] <= 1'b1;
    end
  end

  assign ram_rdata = wr_valid[ram_addr[3:0]] ? ram_mem[ram_addr[3:0]]
                                             : {16'hA5A5, ram_addr[15:0]};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ram_clr = 1'b1;
    if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; hz_stall = 1'b0; br_taken = 1'b0;
    tick; tick;
    check("rst_ram_re", 32'(ram_re), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_freeze_if", 32'(freeze_if), 32'd0);
    check("rst_freeze_pipe", 32'(freeze_pipe), 32'd0);
    rst = 1'b0; ram_clr = 1'b0;

    // Fetch 0x10: five strobe cycles, ready in the seventh cycle.
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    check("f1_freeze_if_req", 32'(freeze_if), 32'd1);
    check("f1_ram_re_idle", 32'(ram_re), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("f1_ram_re", 32'(ram_re), 32'd1);
      check("f1_ram_addr", 32'(ram_addr), 32'd4);
      check("f1_if_ready_early", 32'(if_ready), 32'd0);
    end
    tick;
    check("f1_if_ready", 32'(if_ready), 32'd1);
    check("f1_if_rdata", if_rdata, 32'hA5A50004);
    check("f1_ram_re_done", 32'(ram_re), 32'd0);
    check("f1_freeze_if_done", 32'(freeze_if), 32'd0);
    if_req = 1'b0;
    tick;
    check("f1_if_ready_pulse", 32'(if_ready), 32'd0);
    check("f1_if_rdata_hold", if_rdata, 32'hA5A50004);

    // Store then load at 0x20.
    mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEADBEEF;
    #1;
    check("st_freeze_pipe_req", 32'(freeze_pipe), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("st_ram_we", 32'(ram_we), 32'd1);
      check("st_ram_addr", 32'(ram_addr), 32'd8);
      check("st_freeze_pipe", 32'(freeze_pipe), 32'd1);
    end
    check("st_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick;
    check("st_mem_ready", 32'(mem_ready), 32'd1);
    check("st_freeze_pipe_done", 32'(freeze_pipe), 32'd0);
    check("st_ram_we_done", 32'(ram_we), 32'd0);
    mem_wr = 1'b0;
    tick;
    mem_rd = 1'b1;
    repeat (5) tick;
    check("ld_ram_re", 32'(ram_re), 32'd1);
    tick;
    check("ld_mem_ready", 32'(mem_ready), 32'd1);
    check("ld_mem_rdata", mem_rdata, 32'hDEADBEEF);
    mem_rd = 1'b0;
    tick;

    // Contention: MEM first, IF ready 13 edges after the joint request.
    if_req = 1'b1; if_addr = 32'h14; mem_rd = 1'b1; mem_addr = 32'h24;
    tick;
    check("ct_mem_first_addr", 32'(ram_addr), 32'd9);
    repeat (5) tick;
    check("ct_mem_ready", 32'(mem_ready), 32'd1);
    check("ct_mem_rdata", mem_rdata, 32'hA5A50009);
    check("ct_if_ready_blocked", 32'(if_ready), 32'd0);
    mem_rd = 1'b0;
    tick;
    check("ct_idle_gap_re", 32'(ram_re), 32'd0);
    tick;
    check("ct_if_ram_addr", 32'(ram_addr), 32'd5);
    check("ct_if_ram_re", 32'(ram_re), 32'd1);
    repeat (4) tick;
    check("ct_if_ready_early", 32'(if_ready), 32'd0);
    tick;
    check("ct_if_ready", 32'(if_ready), 32'd1);
    check("ct_if_rdata", if_rdata, 32'hA5A50005);
    if_req = 1'b0;
    tick;

    // Branch in the third IF_ACC cycle aborts the ready pulse.
    if_req = 1'b1; if_addr = 32'h18;
    repeat (3) tick;
    br_taken = 1'b1;
    #1;
    check("br_flush", 32'(flush_if_id), 32'd1);
    tick;
    br_taken = 1'b0;
    check("br_ram_re_continues", 32'(ram_re), 32'd1);
    repeat (2) tick;
    check("br_if_ready_squashed", 32'(if_ready), 32'd0);
    check("br_ram_re_done", 32'(ram_re), 32'd0);
    if_req = 1'b0;
    tick;
    check("br_idle_ready", 32'(if_ready), 32'd0);

    // Flush masked while frozen; then reset during MEM_ACC.
    mem_wr = 1'b1; mem_addr = 32'h30; mem_wdata = 32'h0BADF00D; br_taken = 1'b1;
    #1;
    check("fz_flush_masked", 32'(flush_if_id), 32'd0);
    check("fz_freeze_pipe", 32'(freeze_pipe), 32'd1);
    tick;
    br_taken = 1'b0;
    check("rm_ram_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    tick;
    check("rm_ram_we_cleared", 32'(ram_we), 32'd0);
    check("rm_mem_ready", 32'(mem_ready), 32'd0);
    check("rm_freeze_follows_req", 32'(freeze_pipe), 32'd1);
    rst = 1'b0; mem_wr = 1'b0;
    #1;
    check("rm_freeze_released", 32'(freeze_pipe), 32'd0);
    hz_stall = 1'b1;
    #1;
    check("hz_freeze_if", 32'(freeze_if), 32'd1);
    check("hz_no_pipe", 32'(freeze_pipe), 32'd0);

    // Repeated fetch of 0x40 under hz_stall, then store/refetch.
    if_req = 1'b1; if_addr = 32'h40;
    repeat (6) tick;
    check("bf_first_ready", 32'(if_ready), 32'd1);
    check("bf_first_rdata", if_rdata, 32'hA5A50010);
    tick;
    check("bf_gap_ready", 32'(if_ready), 32'd0);
    tick;
`ifdef IF_BUF_EN
    check("bf_hit_ready", 32'(if_ready), 32'd1);
    check("bf_hit_no_re", 32'(ram_re), 32'd0);
    check("bf_hit_rdata", if_rdata, 32'hA5A50010);
`else
    check("bf_refetch_re", 32'(ram_re), 32'd1);
    check("bf_refetch_not_ready", 32'(if_ready), 32'd0);
    repeat (4) tick;
    tick;
    check("bf_refetch_ready", 32'(if_ready), 32'd1);
`endif
    if_req = 1'b0; hz_stall = 1'b0;
    tick;
    mem_wr = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
    repeat (6) tick;
    check("bs_mem_ready", 32'(mem_ready), 32'd1);
    mem_wr = 1'b0;
    tick;
    if_req = 1'b1; if_addr = 32'h40;
    tick;
    check("bs_refetch_re", 32'(ram_re), 32'd1);
    check("bs_refetch_addr", 32'(ram_addr), 32'h10);
    repeat (4) tick;
    tick;
    check("bs_refetch_ready", 32'(if_ready), 32'd1);
    check("bs_refetch_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
